// File: rtl/frame_uart_tx.sv
// frame_uart_tx: on a rising edge of `full`, reads FRAME_BYTES bytes from the
// decoded-frame mux and sends them as 8N1 UART (LSB first), preceded by a sync
// byte. `rx_hold` mirrors `busy` so the decoder can be frozen while a frame is
// read out. One extra trigger is queued as pending; any further trigger sets
// the sticky overrun flag.
module frame_uart_tx #(
    parameter int          CLKS_PER_BIT = 4,
    parameter int          FRAME_BYTES  = 12,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       full,
    input  logic [7:0] parallel_in,
    output logic [3:0] address,
    output logic       tx,
    output logic       busy,
    output logic       rx_hold,
    output logic       frame_done,
    output logic       overrun
);

    localparam int            CW       = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    IDX_LAST = 4'(FRAME_BYTES - 1);

    typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_t;

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [2:0]    bit_cnt, bit_d;
    logic [3:0]    idx, idx_d;       // data byte index, also drives address
    logic          sync, sync_d;     // current slot is the sync byte
    logic [7:0]    shift, shift_d;
    logic          tx_d, busy_d, done_d;
    logic          pending, pending_d, overrun_d;
    logic          full_q;
    logic          trig, bit_end;

    assign trig    = full & ~full_q;
    assign bit_end = (cnt == CNT_LAST);

    assign address = idx;
    assign rx_hold = busy;

    // Next-state and datapath: every register holds unless its state moves it.
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        bit_d     = bit_cnt;
        idx_d     = idx;
        sync_d    = sync;
        shift_d   = shift;
        busy_d    = busy;
        done_d    = 1'b0;
        pending_d = pending;
        overrun_d = overrun;

        case (state)
            IDLE: begin
                if (trig || pending) begin
                    state_d = LOAD;
                    busy_d  = 1'b1;
                    sync_d  = 1'b1;
                    idx_d   = 4'd0;
                end
            end
            LOAD: begin
                // the only place the mux byte is sampled
                shift_d = sync ? SYNC_BYTE : parallel_in;
                cnt_d   = '0;
                state_d = START;
            end
            START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    bit_d   = 3'd0;
                    state_d = DATA;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    shift_d = {1'b0, shift[7:1]};
                    if (bit_cnt == 3'd7) state_d = STOP;
                    else                 bit_d   = bit_cnt + 3'd1;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (sync) begin
                        sync_d  = 1'b0;
                        idx_d   = 4'd0;
                        state_d = LOAD;
                    end else if (idx == IDX_LAST) begin
                        idx_d   = 4'd0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx + 4'd1;
                        state_d = LOAD;
                    end
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A trigger outside IDLE (including the frame's last cycle) is queued;
        // a second queued trigger is dropped and flagged.
        if (state == IDLE) begin
            if (trig || pending) pending_d = 1'b0;
        end else if (trig) begin
            if (pending) overrun_d = 1'b1;
            else         pending_d = 1'b1;
        end

        // tx is registered from the next state so the line never glitches
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_d;
    end

    // Datapath and output registers; reset aborts any frame with tx high.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt        <= '0;
            bit_cnt    <= 3'd0;
            idx        <= 4'd0;
            sync       <= 1'b0;
            shift      <= 8'd0;
            tx         <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            pending    <= 1'b0;
            overrun    <= 1'b0;
            full_q     <= 1'b0;
        end else begin
            cnt        <= cnt_d;
            bit_cnt    <= bit_d;
            idx        <= idx_d;
            sync       <= sync_d;
            shift      <= shift_d;
            tx         <= tx_d;
            busy       <= busy_d;
            frame_done <= done_d;
            pending    <= pending_d;
            overrun    <= overrun_d;
            full_q     <= full;
        end
    end

endmodule

// File: tb/tb_frame_uart_tx.sv
// Bench for frame_uart_tx: directed stimulus pushes expected bytes into a
// queue per DUT; UART monitors decode tx on the falling clock edge and pop.
module tb_frame_uart_tx;

    localparam int CPB  = 4;
    localparam int CPB2 = 1;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       full, full2;
    logic [7:0] parallel_in, pin2;
    logic [3:0] address, addr2;
    logic       tx, busy, rx_hold, frame_done, overrun;
    logic       tx2, busy2, hold2, done2, ovr2;

    int checks   = 0;
    int failures = 0;

    logic [7:0] q  [$];
    logic [7:0] q2 [$];

    always #5 clock = ~clock;

    // mux model: byte = 0x10 + address
    assign parallel_in = 8'h10 + {4'd0, address};
    assign pin2        = 8'h10 + {4'd0, addr2};

    frame_uart_tx #(.CLKS_PER_BIT(CPB), .FRAME_BYTES(12), .SYNC_BYTE(8'hA5)) dut (
        .clock(clock), .reset_n(reset_n), .full(full), .parallel_in(parallel_in),
        .address(address), .tx(tx), .busy(busy), .rx_hold(rx_hold),
        .frame_done(frame_done), .overrun(overrun));

    frame_uart_tx #(.CLKS_PER_BIT(CPB2), .FRAME_BYTES(1), .SYNC_BYTE(8'hA5)) dut_small (
        .clock(clock), .reset_n(reset_n), .full(full2), .parallel_in(pin2),
        .address(addr2), .tx(tx2), .busy(busy2), .rx_hold(hold2),
        .frame_done(done2), .overrun(ovr2));

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic push_frame();
        q.push_back(8'hA5);
        for (int i = 0; i < 12; i++) q.push_back(8'(8'h10 + i));
    endtask

    // ---------------- monitor for the default DUT ----------------
    bit         m_act  = 0;
    bit         m_prev = 1;
    int         m_t;
    logic [7:0] m_byte;
    always @(negedge clock) begin
        int k;
        if (!reset_n) begin
            m_act  = 0;
            m_prev = 1;
        end else if (!m_act) begin
            if (m_prev && !tx) begin m_act = 1; m_t = 0; end
            m_prev = tx;
        end else begin
            m_t++;
            if (m_t >= CPB + CPB/2 && (m_t - CPB/2) % CPB == 0) begin
                k = (m_t - CPB/2) / CPB - 1;
                if (k < 8) m_byte[k] = tx;
                else begin
                    chk("stop_bit", int'(tx), 1);
                    if (q.size() == 0) chk("extra_byte", int'(m_byte), -1);
                    else chk("uart_byte", int'(m_byte), int'(q.pop_front()));
                    m_act  = 0;
                    m_prev = tx;
                end
            end
        end
    end

    // ---------------- monitor for the 1-clock-per-bit DUT ----------------
    bit         s_act  = 0;
    bit         s_prev = 1;
    int         s_t;
    logic [7:0] s_byte;
    always @(negedge clock) begin
        int k;
        if (!reset_n) begin
            s_act  = 0;
            s_prev = 1;
        end else if (!s_act) begin
            if (s_prev && !tx2) begin s_act = 1; s_t = 0; end
            s_prev = tx2;
        end else begin
            s_t++;
            k = s_t - 1;
            if (k < 8) s_byte[k] = tx2;
            else begin
                chk("small_stop_bit", int'(tx2), 1);
                if (q2.size() == 0) chk("small_extra_byte", int'(s_byte), -1);
                else chk("small_uart_byte", int'(s_byte), int'(q2.pop_front()));
                s_act  = 0;
                s_prev = tx2;
            end
        end
    end

    // Waits (from just after the trigger edge) for frame_done; reports the
    // cycle count and whether address only ever stepped by +1.
    task automatic wait_done(output int n, output int maxa, output bit ok);
        logic [3:0] last;
        last = address; maxa = int'(address); ok = 1; n = -1;
        for (int i = 1; i <= 3000; i++) begin
            @(posedge clock); #1;
            if (frame_done) begin n = i; break; end
            if (address != last) begin
                if (address != last + 4'd1) ok = 0;
                last = address;
                if (int'(address) > maxa) maxa = int'(address);
            end
        end
    endtask

    initial begin
        int n, maxa, nb, nd, d1, d2;
        bit ok;
        reset_n = 1'b0; full = 1'b0; full2 = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_tx", int'(tx), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_addr", int'(address), 0);
        chk("rst_done", int'(frame_done), 0);
        chk("rst_ovr", int'(overrun), 0);
        reset_n = 1'b1;

        // idle: nothing moves
        for (int i = 0; i < 100; i++) begin
            @(posedge clock); #1;
            chk("idle_tx", int'(tx), 1);
            chk("idle_busy", int'(busy), 0);
            chk("idle_hold", int'(rx_hold), 0);
            chk("idle_addr", int'(address), 0);
            chk("idle_done", int'(frame_done), 0);
        end

        // 1 clock per bit, 1 byte: A5 then 0x10, busy 2*11 cycles
        full2 = 1'b1; q2.push_back(8'hA5); q2.push_back(8'h10);
        @(posedge clock); #1; full2 = 1'b0;
        nb = 0; nd = 0;
        for (int i = 0; i < 60; i++) begin
            if (busy2) nb++;
            if (done2) nd++;
            if (hold2 !== busy2) chk("small_hold", int'(hold2), int'(busy2));
            @(posedge clock); #1;
        end
        chk("small_busy_len", nb, 22);
        chk("small_ndone", nd, 1);
        chk("small_ovr", int'(ovr2), 0);

        // single pulse: full frame, 533 cycles
        full = 1'b1; push_frame();
        @(posedge clock); #1; full = 1'b0;
        chk("busy_start", int'(busy), 1);
        wait_done(n, maxa, ok);
        chk("frame_len", n, 533);
        chk("addr_max", maxa, 11);
        chk("addr_step", int'(ok), 1);
        chk("busy_end", int'(busy), 0);
        chk("addr_end", int'(address), 0);
        @(posedge clock); #1;
        chk("done_1cyc", int'(frame_done), 0);

        // full held high: one frame only
        full = 1'b1; push_frame();
        nd = 0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clock); #1;
            if (frame_done) nd++;
        end
        full = 1'b0;
        chk("hold_ndone", nd, 1);

        // second edge at 200 queues, third at 300 overruns
        @(posedge clock); #1;
        full = 1'b1; push_frame();
        @(posedge clock); #1; full = 1'b0;
        d1 = 0; d2 = 0; nd = 0;
        for (int i = 1; i <= 1700; i++) begin
            @(posedge clock); #1;
            if (i == 199) begin full = 1'b1; push_frame(); end
            if (i == 200) full = 1'b0;
            if (i == 250) chk("ovr_two_edges", int'(overrun), 0);
            if (i == 299) full = 1'b1;
            if (i == 300) full = 1'b0;
            if (d1 != 0 && i == d1 + 1) chk("busy_restart", int'(busy), 1);
            if (frame_done) begin
                nd++;
                if (d1 == 0) begin d1 = i; chk("gap_busy_low", int'(busy), 0); end
                else d2 = i;
            end
        end
        chk("done1_at", d1, 533);
        chk("done2_at", d2, 1067);
        chk("two_frames", nd, 2);
        chk("ovr_sticky", int'(overrun), 1);

        // reset in the middle of byte 5's data bits
        full = 1'b1; push_frame();
        @(posedge clock); #1; full = 1'b0;
        repeat (256) @(posedge clock);
        #1;
        chk("mid_tx_low", int'(tx), 0);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_tx", int'(tx), 1);
        chk("arst_busy", int'(busy), 0);
        chk("arst_addr", int'(address), 0);
        chk("arst_ovr", int'(overrun), 0);
        q.delete();
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        @(posedge clock); #1;
        full = 1'b1; push_frame();
        @(posedge clock); #1; full = 1'b0;
        wait_done(n, maxa, ok);
        chk("post_rst_len", n, 533);
        repeat (20) @(posedge clock);
        #1;
        chk("q_empty", q.size(), 0);
        chk("q2_empty", q2.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/frame_uart_tx.md
Name: frame_uart_tx

Overview:
- Downstream consumer of the decoded-frame byte mux.
- When the decoder raises `full`, this block walks the 4-bit byte address 0..11 and captures each byte from the mux's 8-bit parallel output.
- Each frame is sent to the microcontroller as a UART stream (8N1, LSB first), preceded by a sync byte.
- Asserts `rx_hold` while sending, so the microcontroller-side logic can freeze the decoder during readout.

Parameters:
- CLKS_PER_BIT, 4, clock cycles per UART bit; legal range 1..255.
- FRAME_BYTES, 12, number of mux bytes sent per frame (addresses 0..FRAME_BYTES-1); legal range 1..16.
- SYNC_BYTE, 8'hA5, byte sent before the addressed bytes.

Ports:
- clock  input  1  system clock, rising-edge.
- reset_n  input  1  asynchronous active-low reset.
- full  input  1  decoder frame-complete flag; synchronous to clock, level.
- parallel_in  input  8  byte from the mux; combinational function of `address`.
- address  output  4  registered byte-select driven to the mux.
- tx  output  1  UART serial output; idle high.
- busy  output  1  high from frame start until the last stop bit completes.
- rx_hold  output  1  equals `busy`; request to hold the decoder.
- frame_done  output  1  one-cycle pulse when a frame finishes.
- overrun  output  1  sticky; set when a new `full` edge arrives while one is already pending. Cleared only by reset.

Behaviour:
- Reset (async, reset_n=0) forces:
  - tx=1; address=0; busy=0; frame_done=0; overrun=0.
  - state=IDLE; pending=0; full_q=0; baud counter=0; bit counter=0; byte index=0.
  - Reset asserted mid-bit aborts the frame immediately; tx returns high with no partial-byte completion.
- Start trigger is a rising edge of `full`: full=1 and full_q=0 at a clock edge, where full_q is full registered each cycle.
- States: IDLE, LOAD, START, DATA, STOP.
- IDLE:
  - On edge k with trigger (or pending=1), go to LOAD.
  - Set busy=1, byte index=SYNC (internal index -1), address=0, and clear pending.
- LOAD (exactly 1 cycle):
  - Shift register <= SYNC_BYTE for the sync slot, else parallel_in. `address` already equals the byte index during this cycle.
  - Go to START.
- START:
  - tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit count 0.
- DATA:
  - tx=shift[0] for CLKS_PER_BIT cycles per bit, then shift right.
  - After 8 bits, go to STOP.
- STOP:
  - tx=1 for CLKS_PER_BIT cycles.
  - If more bytes remain: index+1, address <= index (data bytes 0..FRAME_BYTES-1), go to LOAD.
  - After the last byte: go to IDLE, busy=0, address=0, frame_done=1 for exactly one cycle.
- tx is registered, with no glitches. tx=1 during LOAD and IDLE.
- Frame length from trigger edge to busy falling: (FRAME_BYTES+1)*(1+10*CLKS_PER_BIT) cycles. Default = 13*41 = 533.
- Trigger edge while busy: set pending=1. If pending is already 1, set overrun=1 and drop the extra edge.
- After frame_done, pending=1 causes IDLE to start the next frame on the very next edge; busy drops for that one IDLE cycle.
- `full` held high continuously produces a single frame; only edges trigger.
- Simultaneous trigger and frame end in the same cycle: the edge goes to pending and is serviced next cycle. It is never lost.
- Byte values are sampled only in LOAD. Mux changes at any other time have no effect.
- Width rules:
  - Baud counter is $clog2(CLKS_PER_BIT+1) bits and wraps at CLKS_PER_BIT-1.
  - Byte index is 5 bits signed, or an equivalent sync flag plus a 4-bit index.

Test Plan:
- Reset then idle 100 cycles -> tx=1, busy=0, address=0, frame_done=0 throughout.
- Model mux returns byte=8'h10+address; pulse full 1 cycle -> UART decode yields A5 10 11 12 … 1B. frame_done pulses exactly 533 cycles after the trigger edge. address steps 0..11, each stable through its LOAD cycle.
- Hold full high for 2000 cycles -> exactly one frame and one frame_done pulse.
- Second full edge at cycle 200 of a frame -> second frame starts 1 cycle after frame_done, overrun=0. Third edge also during that first frame -> overrun=1, only two frames sent.
- Assert reset_n=0 mid-DATA of byte 5 -> tx=1, busy=0 asynchronously. Next full edge -> clean frame starting with A5.
- CLKS_PER_BIT=1, FRAME_BYTES=1 -> frame of A5 then byte 0, busy for 22 cycles, correct bit widths.
